// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - per-frame collision and shot-cleanup sequencer
// Walks ship/asteroid/shot pairs through one shared read port and issues delete requests.
module collision_scheduler #(
  parameter int MAX_ASTEROIDS = 3,
  parameter int MAX_SHOTS     = 3,
  parameter int ENTITY_SIZE   = 34,
  parameter int HIT_DIST      = 16,
  parameter int SHIP_HIT_DIST = 12,
  parameter int X_MAX         = 320,
  parameter int Y_MAX         = 240
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [1:0]             rd_sel,
  output logic [9:0]             rd_idx,
  input  logic [ENTITY_SIZE-1:0] rd_data,
  output logic                   del_valid,
  output logic                   del_sel,
  output logic [9:0]             del_idx,
  input  logic                   del_ready,
  output logic                   ship_hit,
  output logic                   asteroid_killed
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SHIP, S_LATCH_SHIP, S_RD_AST, S_LATCH_AST, S_CHK_SHIP,
    S_RD_SHOT, S_CHK_SHOT, S_DEL_SHOT, S_DEL_AST, S_RD_OOB, S_CHK_OOB,
    S_DEL_OOB, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [9:0]             r_ast_idx;
  logic [9:0]             r_shot_idx;
  logic [MAX_SHOTS-1:0]   r_dead;
  logic                   r_ship_act;
  logic [9:0]             r_ship_x;
  logic [9:0]             r_ship_y;
  logic [9:0]             r_ast_x;
  logic [9:0]             r_ast_y;
  logic                   r_ship_hit_seen;

  logic                   w_ent_act;
  logic [9:0]             w_ent_x;
  logic [9:0]             w_ent_y;
  logic                   w_last_ast;
  logic                   w_last_shot;
  logic [31:0]            w_shot_onehot;
  logic [31:0]            w_dead_ext;
  logic                   w_shot_live;
  logic                   w_shot_hit;
  logic                   w_shot_oob;
  logic                   w_ship_near;
  logic                   w_ship_hit;
  logic [10:0]            w_sdx, w_sdy, w_adx, w_ady;
  logic                   w_unused_bits;

  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  assign w_ent_act     = rd_data[33];
  assign w_ent_y       = rd_data[25:16];
  assign w_ent_x       = rd_data[15:6];
  assign w_unused_bits = ^rd_data;

  assign w_last_ast    = (r_ast_idx  == 10'(MAX_ASTEROIDS - 1));
  assign w_last_shot   = (r_shot_idx == 10'(MAX_SHOTS - 1));

  // Dead mask is indexed through a 32-bit one-hot so any MAX_SHOTS up to 32 works.
  assign w_shot_onehot = 32'd1 << r_shot_idx;
  assign w_dead_ext    = 32'(r_dead);
  assign w_shot_live   = w_ent_act && ((w_dead_ext & w_shot_onehot) == 32'd0);

  assign w_adx         = abs_diff(r_ast_x, w_ent_x);
  assign w_ady         = abs_diff(r_ast_y, w_ent_y);
  assign w_shot_hit    = (w_adx < 11'(HIT_DIST)) && (w_ady < 11'(HIT_DIST));
  assign w_shot_oob    = ({1'b0, w_ent_x} > 11'(X_MAX)) || ({1'b0, w_ent_y} > 11'(Y_MAX));

  assign w_sdx         = abs_diff(r_ship_x, r_ast_x);
  assign w_sdy         = abs_diff(r_ship_y, r_ast_y);
  assign w_ship_near   = (w_sdx < 11'(SHIP_HIT_DIST)) && (w_sdy < 11'(SHIP_HIT_DIST));
  // CHK_SHIP is only reached for an active asteroid, so only the ship flag matters here.
  assign w_ship_hit    = (r_state == S_CHK_SHIP) && r_ship_act && w_ship_near && !r_ship_hit_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (frame_start) w_next = S_RD_SHIP;
      S_RD_SHIP:    w_next = S_LATCH_SHIP;
      S_LATCH_SHIP: w_next = S_RD_AST;
      S_RD_AST:     w_next = S_LATCH_AST;
      S_LATCH_AST: begin
        if (w_ent_act)       w_next = S_CHK_SHIP;
        else if (w_last_ast) w_next = S_RD_OOB;
        else                 w_next = S_RD_AST;
      end
      S_CHK_SHIP:   w_next = S_RD_SHOT;
      S_RD_SHOT:    w_next = S_CHK_SHOT;
      S_CHK_SHOT: begin
        if (w_shot_live && w_shot_hit) w_next = S_DEL_SHOT;
        else if (!w_last_shot)         w_next = S_RD_SHOT;
        else if (w_last_ast)           w_next = S_RD_OOB;
        else                           w_next = S_RD_AST;
      end
      S_DEL_SHOT:   if (del_ready) w_next = S_DEL_AST;
      S_DEL_AST: begin
        if (del_ready) w_next = w_last_ast ? S_RD_OOB : S_RD_AST;
      end
      S_RD_OOB:     w_next = S_CHK_OOB;
      S_CHK_OOB: begin
        if (w_shot_live && w_shot_oob) w_next = S_DEL_OOB;
        else if (w_last_shot)          w_next = S_DONE;
        else                           w_next = S_RD_OOB;
      end
      S_DEL_OOB: begin
        if (del_ready) w_next = w_last_shot ? S_DONE : S_RD_OOB;
      end
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ast_idx       <= '0;
      r_shot_idx      <= '0;
      r_dead          <= '0;
      r_ship_act      <= 1'b0;
      r_ship_x        <= '0;
      r_ship_y        <= '0;
      r_ast_x         <= '0;
      r_ast_y         <= '0;
      r_ship_hit_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_ast_idx       <= '0;
            r_shot_idx      <= '0;
            r_dead          <= '0;
            r_ship_hit_seen <= 1'b0;
          end
        end
        S_LATCH_SHIP: begin
          r_ship_act <= w_ent_act;
          r_ship_x   <= w_ent_x;
          r_ship_y   <= w_ent_y;
        end
        S_LATCH_AST: begin
          r_ast_x <= w_ent_x;
          r_ast_y <= w_ent_y;
          if (!w_ent_act) begin
            r_ast_idx  <= r_ast_idx + 10'd1;
            r_shot_idx <= '0;
          end
        end
        S_CHK_SHIP: begin
          r_shot_idx <= '0;
          if (w_ship_hit) r_ship_hit_seen <= 1'b1;
        end
        S_CHK_SHOT: begin
          if (w_shot_live && w_shot_hit) begin
            r_dead <= r_dead | w_shot_onehot[MAX_SHOTS-1:0];
          end else if (w_last_shot) begin
            r_ast_idx  <= r_ast_idx + 10'd1;
            r_shot_idx <= '0;
          end else begin
            r_shot_idx <= r_shot_idx + 10'd1;
          end
        end
        S_DEL_AST: begin
          if (del_ready) begin
            r_ast_idx  <= r_ast_idx + 10'd1;
            r_shot_idx <= '0;
          end
        end
        S_CHK_OOB: begin
          if (!(w_shot_live && w_shot_oob)) r_shot_idx <= r_shot_idx + 10'd1;
        end
        S_DEL_OOB: begin
          if (del_ready) r_shot_idx <= r_shot_idx + 10'd1;
        end
        S_DONE: begin
          r_dead <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    rd_en           = 1'b0;
    rd_sel          = 2'd0;
    rd_idx          = 10'd0;
    del_valid       = 1'b0;
    del_sel         = 1'b0;
    del_idx         = 10'd0;
    ship_hit        = w_ship_hit;
    asteroid_killed = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_DONE: done = 1'b1;
      default: busy = 1'b1;
    endcase
    case (r_state)
      S_RD_SHIP: begin
        rd_en  = 1'b1;
        rd_sel = 2'd0;
      end
      S_RD_AST: begin
        rd_en  = 1'b1;
        rd_sel = 2'd1;
        rd_idx = r_ast_idx;
      end
      S_RD_SHOT, S_RD_OOB: begin
        rd_en  = 1'b1;
        rd_sel = 2'd2;
        rd_idx = r_shot_idx;
      end
      S_DEL_SHOT, S_DEL_OOB: begin
        del_valid = 1'b1;
        del_sel   = 1'b1;
        del_idx   = r_shot_idx;
      end
      S_DEL_AST: begin
        del_valid       = 1'b1;
        del_sel         = 1'b0;
        del_idx         = r_ast_idx;
        asteroid_killed = del_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - directed self-checking bench for collision_scheduler
module tb_collision_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        del_ready = 1'b0;
  logic        busy, done, rd_en, del_valid, del_sel, ship_hit, asteroid_killed;
  logic [1:0]  rd_sel;
  logic [9:0]  rd_idx, del_idx;
  logic [33:0] rd_data = '0;

  logic [33:0] m_ship;
  logic [33:0] m_ast  [0:2];
  logic [33:0] m_shot [0:2];

  int n_checks = 0;
  int n_fail   = 0;
  int g_cyc = 0, ship_cnt = 0, kill_cnt = 0, done_cnt = 0, bad_rd = 0;
  int fs_cyc = 0, done_cyc = 0;
  logic [10:0] del_log [$];
  int          del_cyc [$];

  logic [28:0] all_out;
  assign all_out = {busy, done, rd_en, rd_sel, rd_idx, del_valid, del_sel, del_idx,
                    ship_hit, asteroid_killed};

  collision_scheduler dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_idx(rd_idx), .rd_data(rd_data),
    .del_valid(del_valid), .del_sel(del_sel), .del_idx(del_idx), .del_ready(del_ready),
    .ship_hit(ship_hit), .asteroid_killed(asteroid_killed)
  );

  always #5 clk = ~clk;

  // Entity RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en && rd_sel == 2'd0)                    rd_data <= m_ship;
    else if (rd_en && rd_sel == 2'd1 && rd_idx < 3) rd_data <= m_ast[int'(rd_idx)];
    else if (rd_en && rd_sel == 2'd2 && rd_idx < 3) rd_data <= m_shot[int'(rd_idx)];
    else                                            rd_data <= '0;
  end

  always @(negedge clk) begin
    g_cyc <= g_cyc + 1;
    if (reset_n) begin
      if (del_valid && del_ready) begin
        del_log.push_back({del_sel, del_idx});
        del_cyc.push_back(g_cyc);
      end
      if (ship_hit)          ship_cnt <= ship_cnt + 1;
      if (asteroid_killed)   kill_cnt <= kill_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= g_cyc;
      end
      if (frame_start && !busy) fs_cyc <= g_cyc;
      if (rd_en && del_valid)   bad_rd <= bad_rd + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ent(input logic act, input int x, input int y);
    return {act, 7'd0, 10'(y), 10'(x), 6'd0};
  endfunction

  function automatic logic [10:0] log_at(input int i);
    if (i < del_log.size()) return del_log[i];
    return 11'h7ff;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < del_cyc.size()) return del_cyc[i];
    return -100;
  endfunction

  task automatic clear_ents();
    m_ship = '0;
    for (int i = 0; i < 3; i++) begin
      m_ast[i]  = '0;
      m_shot[i] = '0;
    end
  endtask

  task automatic start_frame();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_del_valid(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (del_valid) seen = 1'b1;
    end
    check({tag, "_del_valid_seen"}, 64'(seen), 64'd1);
  endtask

  int b_log, b_ship, b_kill, b_done;

  task automatic snap();
    b_log  = del_log.size();
    b_ship = ship_cnt;
    b_kill = kill_cnt;
    b_done = done_cnt;
  endtask

  task automatic setup_t2();
    clear_ents();
    m_ship    = ent(1'b1, 0, 0);
    m_ast[1]  = ent(1'b1, 100, 100);
    m_shot[2] = ent(1'b1, 110, 105);
  endtask

  initial begin
    clear_ents();
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_out), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Reset in the middle of a scan while a delete is pending.
    setup_t2();
    del_ready = 1'b0;
    start_frame();
    wait_del_valid("t1");
    check("t1_del_shot", 64'({del_valid, del_sel, del_idx}), 64'h0C02);
    @(posedge clk); #1 del_ready = 1'b1;
    @(posedge clk); #1 del_ready = 1'b0;
    @(negedge clk);
    check("t1_del_ast_pending", 64'({del_valid, del_sel, del_idx}), 64'h0801);
    reset_n = 1'b0;
    @(negedge clk);
    check("t1_outputs_after_reset", 64'(all_out), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    del_ready = 1'b1;
    snap();
    start_frame();
    @(negedge clk);
    check("t1_first_read_ship", 64'({busy, rd_en, rd_sel, rd_idx}), 64'h3000);
    wait_done("t1");
    check("t1_clean_del_count", 64'(del_log.size() - b_log), 64'd2);
    check("t1_clean_kill", 64'(kill_cnt - b_kill), 64'd1);

    // Single hit: shot 2 on asteroid 1.
    setup_t2();
    snap();
    start_frame();
    wait_done("t2");
    check("t2_del_count", 64'(del_log.size() - b_log), 64'd2);
    check("t2_del0", 64'(log_at(b_log)), 64'h402);
    check("t2_del1", 64'(log_at(b_log + 1)), 64'h001);
    check("t2_back_to_back", 64'(cyc_at(b_log + 1) - cyc_at(b_log)), 64'd1);
    check("t2_kill", 64'(kill_cnt - b_kill), 64'd1);
    check("t2_no_ship_hit", 64'(ship_cnt - b_ship), 64'd0);

    // Two shots on one asteroid: lowest index wins.
    clear_ents();
    m_ast[0]  = ent(1'b1, 50, 50);
    m_shot[0] = ent(1'b1, 52, 52);
    m_shot[1] = ent(1'b1, 52, 52);
    snap();
    start_frame();
    wait_done("t3");
    check("t3_del_count", 64'(del_log.size() - b_log), 64'd2);
    check("t3_del0", 64'(log_at(b_log)), 64'h400);
    check("t3_del1", 64'(log_at(b_log + 1)), 64'h000);
    check("t3_kill", 64'(kill_cnt - b_kill), 64'd1);

    // Ship collision with two asteroids: one pulse, no deletes.
    clear_ents();
    m_ship   = ent(1'b1, 200, 200);
    m_ast[0] = ent(1'b1, 205, 190);
    m_ast[2] = ent(1'b1, 205, 190);
    snap();
    start_frame();
    wait_done("t4");
    check("t4_ship_hit_once", 64'(ship_cnt - b_ship), 64'd1);
    check("t4_no_deletes", 64'(del_log.size() - b_log), 64'd0);
    check("t4_no_kill", 64'(kill_cnt - b_kill), 64'd0);

    // Out-of-bounds boundaries with a stalled first delete.
    clear_ents();
    m_shot[0] = ent(1'b1, 321, 0);
    m_shot[1] = ent(1'b1, 320, 240);
    m_shot[2] = ent(1'b1, 10, 241);
    del_ready = 1'b0;
    snap();
    start_frame();
    wait_del_valid("t5");
    check("t5_stall_start", 64'({del_valid, del_sel, del_idx}), 64'h0C00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t5_stall_%0d", k), 64'({del_valid, del_sel, del_idx, rd_en}), 64'h1800);
    end
    @(posedge clk); #1 del_ready = 1'b1;
    wait_done("t5");
    check("t5_del_count", 64'(del_log.size() - b_log), 64'd2);
    check("t5_del0", 64'(log_at(b_log)), 64'h400);
    check("t5_del1", 64'(log_at(b_log + 1)), 64'h402);

    // Empty scan latency, frame_start during busy ignored.
    clear_ents();
    snap();
    start_frame();
    repeat (3) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_done("t6");
    repeat (30) @(negedge clk);
    check("t6_latency", 64'(done_cyc - fs_cyc + 1), 64'd16);
    check("t6_single_done", 64'(done_cnt - b_done), 64'd1);
    check("t6_idle_after", 64'({busy, done}), 64'd0);

    check("no_read_during_delete", 64'(bad_rd), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
